// File: rtl/spi_flash_sched.sv
// Two-client round-robin command scheduler feeding a byte-level SPI flash engine.
// Expands READ/PROGRAM/ERASE_4K/STATUS into WREN, opcode, address, data and status-poll bytes.
module spi_flash_sched #(
  parameter int unsigned POLL_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op,
  input  logic [47:0] req_addr,
  input  logic [15:0] req_len,
  output logic        grant_id,
  output logic        busy,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        error,
  output logic        eng_start,
  output logic [7:0]  eng_tx,
  output logic        eng_last,
  input  logic        eng_done,
  input  logic [7:0]  eng_rx
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WREN     = 3'd1;
  localparam logic [2:0] CMD      = 3'd2;
  localparam logic [2:0] ADDR     = 3'd3;
  localparam logic [2:0] DATA     = 3'd4;
  localparam logic [2:0] POLL_CMD = 3'd5;
  localparam logic [2:0] POLL_RD  = 3'd6;
  localparam logic [2:0] FIN      = 3'd7;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_STAT  = 2'd3;

  localparam int unsigned PW = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT + 1);

  logic [2:0]    state;
  logic [1:0]    op;
  logic [23:0]   addr;
  logic [7:0]    len;
  logic [8:0]    cnt;
  logic [PW-1:0] poll_cnt;
  logic          rr_ptr;
  logic          inflight;
  logic          kick;

  logic          win;
  logic [1:0]    win_op;
  logic [23:0]   win_addr;
  logic [7:0]    win_len;

  logic [2:0]    nstate;
  logic [8:0]    ncnt;
  logic          fin;
  logic          fin_err;
  logic          fwd;

  logic [2:0]    sel_st;
  logic [8:0]    sel_cnt;
  logic [7:0]    nxt_tx;
  logic          nxt_last;

  always_comb begin
    win      = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
    win_op   = win ? req_op[3:2]     : req_op[1:0];
    win_addr = win ? req_addr[47:24] : req_addr[23:0];
    win_len  = win ? req_len[15:8]   : req_len[7:0];
  end

  // Sequence step taken when the in-flight byte completes.
  always_comb begin
    nstate  = state;
    ncnt    = cnt;
    fin     = 1'b0;
    fin_err = 1'b0;
    fwd     = 1'b0;
    case (state)
      WREN: begin
        nstate = CMD;
        ncnt   = '0;
      end
      CMD: begin
        nstate = (op == OP_STAT) ? DATA : ADDR;
        ncnt   = '0;
      end
      ADDR: begin
        if (cnt == 9'd2) begin
          nstate = (op == OP_ERASE) ? POLL_CMD : DATA;
          ncnt   = '0;
        end else begin
          ncnt = cnt + 9'd1;
        end
      end
      DATA: begin
        if (op == OP_PROG) begin
          if (cnt == {1'b0, len}) nstate = POLL_CMD;
          else                    ncnt = cnt + 9'd1;
        end else begin
          fwd = 1'b1;
          if (op == OP_STAT || cnt == {1'b0, len}) fin = 1'b1;
          else                                     ncnt = cnt + 9'd1;
        end
      end
      POLL_CMD: nstate = POLL_RD;
      POLL_RD: begin
        if (!eng_rx[0]) begin
          fin = 1'b1;
        end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          nstate = POLL_CMD;
        end
      end
      default: ;
    endcase
  end

  // Byte to launch: for the next position on completion, else for the current one.
  always_comb begin
    sel_st   = inflight ? nstate : state;
    sel_cnt  = inflight ? ncnt : cnt;
    nxt_tx   = 8'hff;
    nxt_last = 1'b0;
    case (sel_st)
      WREN: begin
        nxt_tx   = 8'h06;
        nxt_last = 1'b1;
      end
      CMD: begin
        case (op)
          OP_READ:  nxt_tx = 8'h03;
          OP_PROG:  nxt_tx = 8'h02;
          OP_ERASE: nxt_tx = 8'h20;
          default:  nxt_tx = 8'h05;
        endcase
      end
      ADDR: begin
        case (sel_cnt[1:0])
          2'd0:    nxt_tx = addr[23:16];
          2'd1:    nxt_tx = addr[15:8];
          default: nxt_tx = addr[7:0];
        endcase
        nxt_last = (op == OP_ERASE) && (sel_cnt == 9'd2);
      end
      DATA:     nxt_last = (op == OP_STAT) || (sel_cnt == {1'b0, len});
      POLL_CMD: nxt_tx = 8'h05;
      POLL_RD:  nxt_last = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      op        <= OP_READ;
      addr      <= '0;
      len       <= '0;
      cnt       <= '0;
      poll_cnt  <= '0;
      rr_ptr    <= 1'b0;
      inflight  <= 1'b0;
      kick      <= 1'b0;
      req_ready <= '0;
      grant_id  <= 1'b0;
      busy      <= 1'b0;
      wr_ready  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      eng_start <= 1'b0;
      eng_tx    <= 8'hff;
      eng_last  <= 1'b0;
    end else begin
      req_ready <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      eng_start <= 1'b0;
      if (state != IDLE) busy <= 1'b1;

      if (state == IDLE) begin
        if (|req_valid) begin
          req_ready <= win ? 2'b10 : 2'b01;
          grant_id  <= win;
          rr_ptr    <= ~win;
          op        <= win_op;
          addr      <= win_addr;
          len       <= win_len;
          cnt       <= '0;
          poll_cnt  <= '0;
          kick      <= 1'b1;
          state     <= (win_op == OP_PROG || win_op == OP_ERASE) ? WREN : CMD;
        end
      end else if (state == FIN) begin
        state <= IDLE;
      end else if (kick) begin
        kick      <= 1'b0;
        inflight  <= 1'b1;
        eng_start <= 1'b1;
        eng_tx    <= nxt_tx;
        eng_last  <= nxt_last;
      end else if (inflight) begin
        if (eng_done) begin
          inflight <= 1'b0;
          state    <= nstate;
          cnt      <= ncnt;
          if (fwd) begin
            rd_valid <= 1'b1;
            rd_data  <= eng_rx;
          end
          if (state == POLL_RD && !fin) poll_cnt <= poll_cnt + 1'b1;
          // Completion retires straight to IDLE so a new accept can land while done is visible.
          if (fin) begin
            done  <= 1'b1;
            error <= fin_err;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (nstate == DATA && op == OP_PROG) begin
            wr_ready <= 1'b1;
          end else begin
            inflight  <= 1'b1;
            eng_start <= 1'b1;
            eng_tx    <= nxt_tx;
            eng_last  <= nxt_last;
          end
        end
      end else if (state == DATA && op == OP_PROG && wr_valid && wr_ready) begin
        wr_ready  <= 1'b0;
        inflight  <= 1'b1;
        eng_start <= 1'b1;
        eng_tx    <= wr_data;
        eng_last  <= nxt_last;
      end
    end
  end

endmodule

// File: doc/spi_flash_sched.md
# spi_flash_sched

Command scheduler between two flash clients and the byte-level SPI engine that drives the configuration flash pins. It arbitrates requests round-robin and expands each into the flash byte sequence: optional WREN (0x06), opcode, 24-bit address, data phase, then status polling (0x05) until write-in-progress clears. It keeps the engine single-owner and never starts a byte before the previous one completes.

## Interface
Parameters:
- POLL_LIMIT, 1023: max status polls per program/erase before timeout.

Ports (reset n_rst, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- n_rst  in  1  async active-low reset
- req_valid  in  2  request from client i
- req_ready  out  2  one-hot accept pulse
- req_op  in  4  client i at [2i+1:2i]: 0 READ, 1 PROGRAM, 2 ERASE_4K, 3 STATUS
- req_addr  in  48  client i at [24i+23:24i]
- req_len  in  16  client i at [8i+7:8i]; data bytes = len+1
- grant_id  out  1  client owning current command
- busy  out  1  high from accept through done
- wr_data  in  8  program byte from granted client
- wr_valid  in  1  program byte valid
- wr_ready  out  1  scheduler takes program byte
- rd_data  out  8  read/status byte
- rd_valid  out  1  one-cycle pulse per returned byte
- done  out  1  one-cycle pulse, command complete
- error  out  1  one-cycle pulse with done on poll timeout
- eng_start  out  1  one-cycle pulse, send eng_tx
- eng_tx  out  8  byte to shift out
- eng_last  out  1  engine raises CS after this byte
- eng_done  in  1  one-cycle pulse, byte finished
- eng_rx  in  8  byte shifted in, valid with eng_done

## Operation
- States: IDLE, WREN, CMD, ADDR, DATA, POLL_CMD, POLL_RD, FIN.
- IDLE: if any req_valid, accept exactly one; round-robin, pointer resets so client 0 wins first; with both valid, alternate. Latch op/addr/len/grant_id; pulse req_ready[id]. Never accept outside IDLE.
- PROGRAM and ERASE_4K: WREN as a single byte with eng_last=1, then CMD. READ and STATUS go straight to CMD.
- CMD: opcode 0x03 / 0x02 / 0x20 / 0x05. STATUS: eng_last=0, then one dummy 0xFF with eng_last=1, eng_rx returned on rd_data, then FIN.
- ADDR: three bytes, addr[23:16], [15:8], [7:0]. ERASE_4K sets eng_last on the final address byte, then POLL_CMD.
- DATA (READ): len+1 dummy 0xFF bytes, each eng_rx forwarded on rd_data/rd_valid; last has eng_last=1; then FIN.
- DATA (PROGRAM): wr_ready high while engine idle and bytes remain; each wr_valid&&wr_ready sends wr_data; last byte has eng_last=1; then POLL_CMD. Stall indefinitely while wr_valid low.
- POLL_CMD/POLL_RD: 0x05 (eng_last=0) then 0xFF (eng_last=1). If eng_rx[0]=0, go to FIN. Else increment poll counter and repeat. If counter reaches POLL_LIMIT with bit0 still 1, go to FIN with error. Poll bytes are not forwarded to rd_valid.
- FIN: pulse done (and error if timed out); clear busy; return to IDLE.
- Byte counter is 9 bits; len=8'hff gives 256 bytes, no wrap. Address does not increment.

## Timing
- Reset values: req_ready=0, grant_id=0, busy=0, wr_ready=0, rd_data=0, rd_valid=0, done=0, error=0, eng_start=0, eng_tx=8'hff, eng_last=0. State IDLE, RR pointer favours client 0, poll counter 0.
- All outputs registered.
- Accept in cycle N (req_ready pulse) drives busy=1 and the first eng_start in N+1.
- Each next eng_start comes exactly one cycle after the eng_done of the previous byte.
- eng_tx and eng_last are held stable from eng_start until eng_done.
- rd_valid/rd_data come one cycle after the matching eng_done.
- done asserts one cycle after the final eng_done; busy falls with done. A new accept is possible the cycle after done.
- Program byte: a handshake in cycle M drives eng_start in M+1; wr_ready is low from the handshake until that byte's eng_done.
- req_valid changes after accept are ignored; the latched descriptor rules.
- n_rst mid-command returns all outputs to reset values immediately; no done is issued. The engine shares n_rst.

## Test plan
- Client 0 READ addr 0x000000, len 1 -> eng bytes 03 00 00 00 FF FF (last on sixth); rd_valid twice with eng_rx values; done; 6 eng_start pulses.
- Client 1 PROGRAM addr 0x000010, len 1, data DE AD; status returns 01,01,00 -> 06(last), 02 00 00 10 DE AD(last), three 05/FF polls, done, no error.
- Both clients valid continuously with STATUS -> grants 0,1,0,1; each rd_valid carries the dummy-cycle eng_rx.
- ERASE_4K with status stuck at 01, POLL_LIMIT=3 -> exactly 3 polls, then done and error in the same cycle.
- PROGRAM, wr_valid held low 20 cycles after the address -> no eng_start during the stall; resumes one cycle after the handshake.
- n_rst pulse during READ data phase -> busy, rd_valid and eng_start low at once; afterwards client 0 wins the first grant again.
